bitwise_logic_unit: RTL

//  Parametrised, registered successor to the fixed 4-bit XOR datapath.
//  Per-beat bitwise op (XOR/AND/OR/XNOR) on two WIDTH-bit operands, with a

---
 rtl/bitwise_logic_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: registered per-beat bitwise op (XOR/AND/OR/XNOR) on two
// WIDTH-bit operands, with a frame-accumulate mode that XOR-folds op results
// into a running checksum. Valid/ready streaming on input and output.
// Optional feature macro: BLU_PARITY_EN adds out_parity = ^out_data.
module bitwise_logic_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  input  logic             accum,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_frame
`ifdef BLU_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] fold_c;
  logic             accept_c;

  // Output slot is free when empty or being drained this cycle: no bubble
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Per-beat bitwise result at full width
  always_comb begin
    res_c = '0;
    unique case (op)
      2'b00: res_c = in_a ^ in_b;
      2'b01: res_c = in_a & in_b;
      2'b10: res_c = in_a | in_b;
      2'b11: res_c = ~(in_a ^ in_b);
    endcase
  end

  assign fold_c = acc ^ res_c;

  // Frame tracking, accumulator and registered output slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_frame <= 1'b0;
`ifdef BLU_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      // Consumer took the held result; a new result below overrides this
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept_c) begin
        if (!accum) begin
          // Pass-through beat: acc and frame state untouched
          out_data  <= res_c;
          out_frame <= 1'b0;
          out_valid <= 1'b1;
`ifdef BLU_PARITY_EN
          out_parity <= ^res_c;
`endif
        end else if (!in_last) begin
          acc <= fold_c;
        end else begin
          // Closing beat: emit checksum and restart the frame from zero
          out_data  <= fold_c;
          out_frame <= 1'b1;
          out_valid <= 1'b1;
          acc       <= '0;
`ifdef BLU_PARITY_EN
          out_parity <= ^fold_c;
`endif
        end
        unique case (state)
          S_IDLE: if (accum && !in_last) state <= S_ACC;
          S_ACC:  if (accum && in_last)  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
